// File: rtl/sparc_exu_div_satgen_pkg.sv
// Shared exu definitions for the divider quotient saturation stage:
// 32-bit saturation constants, stage-valid encoding and the S2 result select.
package sparc_exu_div_satgen_pkg;

  localparam logic [31:0] SAT_POS32 = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG32 = 32'h8000_0000;
  localparam logic [31:0] SAT_U32   = 32'hFFFF_FFFF;

  typedef enum logic {
    STG_EMPTY = 1'b0,
    STG_FULL  = 1'b1
  } stg_vld_e;

  typedef struct packed {
    logic [31:0] lo;
    logic        is_signed;
    logic        msb;
    logic        u_hi;
    logic        u_lo;
    logic        z_hi;
  } s1_data_t;

  // u_hi and u_lo overlap on bit 47, so together they cover all of [63:31].
  function automatic logic [32:0] sat_select(input s1_data_t s1);
    logic        ovf;
    logic [31:0] res;
    ovf = s1.is_signed ? ~(s1.u_hi & s1.u_lo) : ~s1.z_hi;
    if (!ovf)
      res = s1.lo;
    else if (!s1.is_signed)
      res = SAT_U32;
    else
      res = s1.msb ? SAT_NEG32 : SAT_POS32;
    return {ovf, res};
  endfunction

endpackage

// File: rtl/sparc_exu_div_satgen_chk.sv
// Uniformity detector: high when all 17 input bits carry the same value.
module sparc_exu_satgen_chk (
  input  logic [16:0] din,
  output logic        same
);

  assign same = (&din) | ~(|din);

endmodule

// File: rtl/sparc_exu_div_satgen.sv
// Two-stage quotient saturation pipeline: S1 captures the overflow checks,
// S2 selects the saturated or pass-through 32-bit result behind a valid/ready handshake.
module sparc_exu_div_satgen
  import sparc_exu_div_satgen_pkg::*;
(
  input  logic        rclk,
  input  logic        rst_l,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [63:0] in_data,
  input  logic        in_signed,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_data,
  output logic        out_ovf
);

  stg_vld_e    s1_stg;
  stg_vld_e    out_stg;
  s1_data_t    s1_d;
  s1_data_t    s1_q;
  logic        u_hi;
  logic        u_lo;
  logic        s1_vld;
  logic        s2_adv;
  logic        in_xfer;
  logic        s2_load;
  logic [32:0] sel;

  sparc_exu_satgen_chk u_hi_chk (
    .din  (in_data[63:47]),
    .same (u_hi)
  );

  sparc_exu_satgen_chk u_lo_chk (
    .din  (in_data[47:31]),
    .same (u_lo)
  );

  assign s1_vld  = (s1_stg == STG_FULL);
  assign out_vld = (out_stg == STG_FULL);
  assign s2_adv  = ~out_vld | out_rdy;
  assign in_rdy  = ~s1_vld | s2_adv;
  assign in_xfer = in_vld & in_rdy;
  assign s2_load = s1_vld & s2_adv;
  assign sel     = sat_select(s1_q);

  always_comb begin
    s1_d           = '0;
    s1_d.lo        = in_data[31:0];
    s1_d.is_signed = in_signed;
    s1_d.msb       = in_data[63];
    s1_d.u_hi      = u_hi;
    s1_d.u_lo      = u_lo;
    s1_d.z_hi      = ~(|in_data[63:32]);
  end

  // Only the stage valids are reset; S1 empties into S2 whenever S2 can advance.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      s1_stg  <= STG_EMPTY;
      out_stg <= STG_EMPTY;
    end else begin
      if (in_rdy)
        s1_stg <= in_vld ? STG_FULL : STG_EMPTY;
      if (s2_adv)
        out_stg <= s1_vld ? STG_FULL : STG_EMPTY;
    end
  end

  always_ff @(posedge rclk) begin
    if (in_xfer)
      s1_q <= s1_d;
    if (s2_load)
      {out_ovf, out_data} <= sel;
  end

endmodule

// File: tb/tb_sparc_exu_div_satgen.sv
// Self-checking bench for sparc_exu_div_satgen: directed vector table, stall,
// throughput, reset-flush and randomized handshake streams against a scoreboard.
module tb_sparc_exu_div_satgen;

  typedef struct {
    logic [63:0] data;
    logic        sgn;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  logic        rclk;
  logic        rst_l;
  logic        in_vld;
  logic        in_rdy;
  logic [63:0] in_data;
  logic        in_signed;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_data;
  logic        out_ovf;

  logic [32:0] sb[$];
  int          pass_cnt;
  int          total_cnt;
  int          out_cnt;
  vec_t        vecs[14];

  sparc_exu_div_satgen dut (
    .rclk      (rclk),
    .rst_l     (rst_l),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Independent reference: range test on the full 64-bit value.
  function automatic logic [32:0] model(input logic [63:0] d, input logic s);
    if (s) begin
      if ($signed(d) > 64'sh0000_0000_7FFF_FFFF)
        return {1'b1, 32'h7FFF_FFFF};
      else if ($signed(d) < 64'shFFFF_FFFF_8000_0000)
        return {1'b1, 32'h8000_0000};
      else
        return {1'b0, d[31:0]};
    end else begin
      if (d > 64'h0000_0000_FFFF_FFFF)
        return {1'b1, 32'hFFFF_FFFF};
      else
        return {1'b0, d[31:0]};
    end
  endfunction

  // Drives one input for one cycle; pushes the expectation if it transfers.
  task automatic applyStimulus(input logic [63:0] d, input logic s, input logic [32:0] exp,
                               output logic accepted);
    in_vld    = 1'b1;
    in_data   = d;
    in_signed = s;
    @(negedge rclk);
    accepted = in_vld && in_rdy && rst_l;
    if (accepted)
      sb.push_back(exp);
    @(posedge rclk);
    #1;
  endtask

  always @(negedge rclk) begin
    if (rst_l && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        checkOutput("out_data", out_data, e[31:0]);
        checkOutput("out_ovf", {31'd0, out_ovf}, {31'd0, e[32]});
      end
      out_cnt++;
    end
  end

  initial begin
    logic        acc;
    int          n;
    int          base;
    int          idx;
    int          accepts;
    logic [63:0] items[8];
    logic        isgn[8];

    pass_cnt  = 0;
    total_cnt = 0;
    out_cnt   = 0;

    vecs[0]  = '{64'h0000_0000_7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0};
    vecs[1]  = '{64'hFFFF_FFFF_7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1};
    vecs[2]  = '{64'h0000_0000_8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[3]  = '{64'h0000_0001_0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{64'h0000_0000_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{64'hFFFF_FFFF_8000_0000, 1'b1, 32'h8000_0000, 1'b0};
    vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{64'h0000_8000_0000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{64'h0000_0000_1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[10] = '{64'h8000_0000_0000_0000, 1'b1, 32'h8000_0000, 1'b1};
    vecs[11] = '{64'h0000_0000_0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[12] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[13] = '{64'hFFFF_7FFF_FFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1};

    rst_l     = 1'b0;
    in_vld    = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_rdy   = 1'b1;
    repeat (3) @(posedge rclk);
    #1;
    rst_l = 1'b1;
    @(negedge rclk);
    checkOutput("reset_out_vld", {31'd0, out_vld}, 32'd0);
    checkOutput("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
    @(posedge rclk);
    #1;

    // Directed table: one item at a time, latency and result checked.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].data, vecs[i].sgn, {vecs[i].exp_ovf, vecs[i].exp_data}, acc);
      in_vld = 1'b0;
      checkOutput("vec_accept", {31'd0, acc}, 32'd1);
      n = 1;
      while (!out_vld && n < 10) begin
        @(posedge rclk);
        #1;
        n++;
      end
      checkOutput("vec_latency", n, 32'd2);
      @(posedge rclk);
      #1;
    end

    // Back-to-back throughput with out_rdy held high.
    base = out_cnt;
    for (int i = 0; i < 8; i++) begin
      logic [63:0] d;
      d = {{32{i[0]}}, $urandom()};
      applyStimulus(d, i[1], model(d, i[1]), acc);
      checkOutput("thru_accept", {31'd0, acc}, 32'd1);
    end
    in_vld = 1'b0;
    @(posedge rclk);
    #1;
    @(posedge rclk);
    #1;
    checkOutput("thru_count", out_cnt - base, 32'd8);

    // Stall: out_rdy low for 5 cycles, then release.
    for (int i = 0; i < 8; i++) begin
      items[i] = (i % 3 == 0) ? {32'h0000_0001, $urandom()} : {32'h0, $urandom()};
      isgn[i]  = i[0];
    end
    base    = out_cnt;
    idx     = 0;
    accepts = 0;
    for (int cyc = 0; cyc < 60 && (idx < 8 || sb.size() != 0); cyc++) begin
      out_rdy = (cyc >= 5);
      if (idx < 8) begin
        applyStimulus(items[idx], isgn[idx], model(items[idx], isgn[idx]), acc);
        if (acc) begin
          idx++;
          accepts++;
        end
      end else begin
        in_vld = 1'b0;
        @(posedge rclk);
        #1;
      end
      if (cyc == 2)
        checkOutput("stall_in_rdy", {31'd0, in_rdy}, 32'd0);
      if (cyc == 4)
        checkOutput("stall_accepts", accepts, 32'd2);
    end
    in_vld = 1'b0;
    checkOutput("stall_all_sent", idx, 32'd8);
    checkOutput("stall_out_count", out_cnt - base, 32'd8);

    // Reset with both stages full and out_rdy low.
    out_rdy = 1'b0;
    applyStimulus(64'h0000_0000_0000_0011, 1'b0, {1'b0, 32'h11}, acc);
    applyStimulus(64'h0000_0000_0000_0022, 1'b0, {1'b0, 32'h22}, acc);
    rst_l   = 1'b0;
    in_vld  = 1'b1;
    in_data = 64'h0000_0000_0000_0033;
    sb.delete();
    @(posedge rclk);
    #1;
    rst_l  = 1'b1;
    in_vld = 1'b0;
    checkOutput("rst_out_vld", {31'd0, out_vld}, 32'd0);
    checkOutput("rst_s1_empty", {31'd0, in_rdy}, 32'd1);
    out_rdy = 1'b1;
    base    = out_cnt;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, {1'b0, 32'hFFFF_FFFE}, acc);
    in_vld = 1'b0;
    checkOutput("rst_post_accept", {31'd0, acc}, 32'd1);
    n = 1;
    while (!out_vld && n < 10) begin
      @(posedge rclk);
      #1;
      n++;
    end
    checkOutput("rst_post_latency", n, 32'd2);
    repeat (3) @(posedge rclk);
    #1;
    checkOutput("rst_post_count", out_cnt - base, 32'd1);

    // Randomized valid/ready handshake with mixed magnitudes.
    idx = 0;
    for (int cyc = 0; cyc < 400 && idx < 40; cyc++) begin
      logic [63:0] d;
      logic        s;
      out_rdy = ($urandom_range(0, 2) != 0);
      s = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: d = {{32{1'b0}}, $urandom()};
        1: begin
          d[31:0]  = $urandom();
          d[63:32] = {32{d[31]}};
        end
        2: d = {$urandom(), $urandom()};
        default: d = {{31{1'b1}}, $urandom_range(0, 1) == 1, $urandom()};
      endcase
      if ($urandom_range(0, 3) != 0) begin
        applyStimulus(d, s, model(d, s), acc);
        if (acc)
          idx++;
      end else begin
        in_vld = 1'b0;
        @(posedge rclk);
        #1;
      end
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge rclk);
      #1;
      n++;
    end
    checkOutput("rand_sent", idx, 32'd40);
    checkOutput("rand_drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
